// File: rtl/chacha_ks_prefetch_buf.sv
// Keystream prefetch buffer: requests 512-bit ChaCha20 blocks ahead of demand,
// tags each with its block counter and serves them as LANE_BYTES-wide slices.
module chacha_ks_prefetch_buf #(
  parameter int unsigned LANE_BYTES = 16,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [31:0]             ctr_init,
  output logic                    gen_req,
  input  logic                    gen_valid,
  input  logic [511:0]            gen_data,
  output logic                    ks_valid,
  input  logic                    ks_ready,
  output logic [LANE_BYTES*8-1:0] ks_data,
  output logic [31:0]             ks_ctr,
  output logic                    ks_last,
  output logic [3:0]              level,
  output logic                    ctr_wrap_err
);

  localparam int unsigned NSLICE = 64 / LANE_BYTES;
  localparam int unsigned LANE_W = LANE_BYTES * 8;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [511:0]      blk_mem [DEPTH];
  logic [31:0]       tag_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [3:0]        count;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       ctr_next;
  logic              armed;
  logic              pending;
  logic              drop;
  logic              exhausted;

  logic              fifo_full;
  logic              accept;
  logic              push;
  logic              pop;
  logic              pop_blk;
  logic              last_slice;
  logic [511:0]      head_blk;
  logic [LANE_W-1:0] head_slice;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    ks_valid   = (count != 4'd0);
    last_slice = (idx == IDX_W'(NSLICE - 1));
    head_blk   = blk_mem[rd_ptr];
    head_slice = LANE_W'(head_blk >> (32'(idx) * LANE_W));
    fifo_full  = (count == 4'(DEPTH));
    // Space is reserved at request time, so a response can never meet a full FIFO.
    gen_req    = armed & ~pending & ~exhausted & ~cfg_we & ~fifo_full;
    accept     = gen_valid & pending;
    push       = accept & ~drop & ~cfg_we;
    pop        = ks_valid & ks_ready & ~cfg_we;
    pop_blk    = pop & last_slice;
    ks_data    = ks_valid ? head_slice : '0;
    ks_ctr     = ks_valid ? tag_mem[rd_ptr] : '0;
    ks_last    = ks_valid & last_slice;
    level      = count + {3'b000, pending};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      blk_mem[wr_ptr] <= gen_data;
      tag_mem[wr_ptr] <= ctr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      idx          <= '0;
      ctr_next     <= '0;
      armed        <= 1'b0;
      pending      <= 1'b0;
      drop         <= 1'b0;
      exhausted    <= 1'b0;
      ctr_wrap_err <= 1'b0;
    end else if (cfg_we) begin
      ctr_next     <= ctr_init;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      idx          <= '0;
      armed        <= 1'b1;
      exhausted    <= 1'b0;
      ctr_wrap_err <= 1'b0;
      // A response landing in this cycle is swallowed here; one still in flight is marked stale.
      if (accept) begin
        pending <= 1'b0;
        drop    <= 1'b0;
      end else if (pending) begin
        drop <= 1'b1;
      end
    end else begin
      if (gen_req) begin
        pending <= 1'b1;
      end
      if (accept) begin
        pending <= 1'b0;
        drop    <= 1'b0;
      end
      if (push) begin
        wr_ptr   <= ptr_inc(wr_ptr);
        ctr_next <= ctr_next + 32'd1;
        if (ctr_next == 32'hFFFF_FFFF) begin
          exhausted    <= 1'b1;
          ctr_wrap_err <= 1'b1;
        end
      end
      if (pop) begin
        if (last_slice) begin
          idx    <= '0;
          rd_ptr <= ptr_inc(rd_ptr);
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
      count <= count + {3'b000, push} - {3'b000, pop_blk};
    end
  end

endmodule

// File: doc/chacha_ks_prefetch_buf.md
Name: chacha_ks_prefetch_buf

Overview:
Parametrised keystream prefetch buffer between the ChaCha20 keystream generator (512-bit block per request) and the payload XOR datapath. After configuration it issues block requests ahead of demand and tags each block with its 32-bit block counter. It buffers up to DEPTH blocks and serves them as LANE_BYTES-wide slices under valid/ready. Adds counter-wrap protection and flush-on-reconfigure, which the single-block core path lacks.

Parameters:
LANE_BYTES, 16, output slice width in bytes; legal 16/32/64; NSLICE = 64/LANE_BYTES
DEPTH, 2, buffered 512-bit blocks; legal 1..8

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  load ctr_init, flush buffer, arm prefetch
ctr_init  in  32  first block counter
gen_req  out  1  one-cycle block request to generator
gen_valid  in  1  generator block returned (one cycle)
gen_data  in  512  keystream block, byte 0 in [7:0]
ks_valid  out  1  slice available
ks_ready  in  1  consumer accepts slice
ks_data  out  LANE_BYTES*8  current slice
ks_ctr  out  32  block counter of current slice
ks_last  out  1  current slice is last of its block
level  out  4  buffered blocks plus in-flight request
ctr_wrap_err  out  1  sticky: counter exhausted

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FIFO empty; slice index 0; disarmed; ctr_next=0; pending=0; drop=0.
- cfg_we (synchronous, one cycle): ctr_next<=ctr_init; FIFO cleared; slice index 0; armed=1; ctr_wrap_err<=0; exhausted<=0. If a request is pending, set drop=1 so that response is discarded. gen_req is not asserted in the cfg_we cycle.
- Request rule: at most one request outstanding. gen_req=1 for one cycle when armed, pending=0, exhausted=0, cfg_we=0 and (entries < DEPTH). Then pending<=1.
- Response: on gen_valid with drop=1: pending<=0, drop<=0, nothing written. Otherwise push {gen_data, ctr_next}, pending<=0, ctr_next<=ctr_next+1.
  - If the accepted counter is 32'hFFFFFFFF: exhausted<=1 and ctr_wrap_err<=1. No further gen_req until cfg_we. ctr_next wraps to 0 but is never used.
- gen_valid while pending=0 is ignored (no push).
- Output: ks_valid = FIFO non-empty. ks_data = head block bytes [idx*LANE_BYTES +: LANE_BYTES]. ks_ctr = head tag. ks_last = (idx==NSLICE-1).
  - ks_data, ks_ctr and ks_last are 0 when ks_valid=0.
- Pop: on ks_valid&ks_ready, idx++. On the last slice, the head entry is freed and idx<=0.
- Latency: block pushed at edge t is visible with ks_valid=1 after edge t (registered FIFO, no bypass). Push and pop in the same cycle are both honoured. Push never occurs when full, because space is reserved at request time.
- level = entries + pending, range 0..DEPTH.
- cfg_we together with gen_valid in the same cycle: the response is discarded and drop is not set. cfg_we together with a pop: cfg_we wins (flush).
- ks_valid and data are held stable while ks_ready=0.

Test Plan:
- Basic: LANE_BYTES=16, DEPTH=2, ctr_init=1, generator latency 3, ks_ready=1, gen_data=byte pattern k*64+i. Required: slices [127:0],[255:128],[383:256],[511:384] with ks_ctr=1; ks_last on the 4th slice; next block has ks_ctr=2 and contiguous data.
- Backpressure: ks_ready=0 for 30 cycles after cfg_we. Required: exactly 2 gen_req pulses; level=2; ks_data stable. On release, 8 slices stream back-to-back and a 3rd gen_req follows the first block free.
- Wrap: ctr_init=32'hFFFFFFFE. Required: blocks with ctr FFFFFFFE and FFFFFFFF delivered; ctr_wrap_err=1 after the second accept; no third gen_req; cfg_we clears ctr_wrap_err and prefetch restarts.
- Reconfigure mid-flight: cfg_we while pending, with ctr_init=5. Required: the stale gen_valid is dropped (ks_valid stays 0); the next delivered block has ks_ctr=5; the same-cycle cfg_we+gen_valid case also drops.
- Width sweep: LANE_BYTES=64, DEPTH=4. Required: ks_last=1 on every slice; 4 blocks prefetched with ctr n..n+3; level ≤4 always.
- Async reset while level=2 and mid-block (idx=2). Required: all outputs 0 immediately; after release, no gen_req until cfg_we.
